// File: rtl/ct_loader.sv
// Packs 32-bit ciphertext chunks LSB-first into W-bit ct memory rows; CPR+1 cycles per row, din stalls only during WRITE/DONE/IDLE.
// Build with CT_LOAD_CHK_EN to add the sticky err flag for nonzero padding / unused lanes.
module ct_loader #(
  parameter int M     = 79,
  parameter int N     = 47,
  parameter int DIGIT = 4,
  localparam int W    = M * DIGIT,
  localparam int ROWS = (N + DIGIT - 1) / DIGIT,
  localparam int CPR  = (W + 31) / 32,
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [31:0]   din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [AW-1:0] ct_addr,
  output logic [W-1:0]  ct_dout,
  output logic          ct_rw,
  output logic          busy,
  output logic          done
`ifdef CT_LOAD_CHK_EN
  ,
  output logic          err
`endif
);

  localparam int CW = (CPR > 1) ? $clog2(CPR) : 1;

  // Padding bits above W are only kept when something inspects them.
`ifdef CT_LOAD_CHK_EN
  localparam int AWID = CPR * 32;
`else
  localparam int AWID = W;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_chunk;
  logic [AW-1:0]   r_row;
  logic [AWID-1:0] r_asm;
  logic            w_write;
  logic            w_last_row;

  assign w_write    = (r_state == S_WRITE);
  assign w_last_row = (r_row == AW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= S_IDLE;
      r_chunk <= '0;
      r_row   <= '0;
      r_asm   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RECV;
            r_chunk <= '0;
            r_row   <= '0;
          end
        end
        S_RECV: begin
          if (din_valid) begin
            for (int b = 0; b < AWID; b++) begin
              if (r_chunk == CW'(b / 32)) r_asm[b] <= din[b % 32];
            end
            if (r_chunk == CW'(CPR - 1)) begin
              r_chunk <= '0;
              r_state <= S_WRITE;
            end else begin
              r_chunk <= r_chunk + CW'(1);
            end
          end
        end
        S_WRITE: begin
          if (w_last_row) begin
            r_state <= S_DONE;
          end else begin
            r_row   <= r_row + AW'(1);
            r_state <= S_RECV;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-side outputs are zero outside WRITE so several masters can be OR-merged.
  assign din_ready = (r_state == S_RECV);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ct_rw     = w_write;
  assign ct_addr   = w_write ? r_row : '0;
  assign ct_dout   = w_write ? r_asm[W-1:0] : '0;

`ifdef CT_LOAD_CHK_EN
  localparam int REM = N % DIGIT;
  localparam logic [AWID-1:0] PAD_MASK  = {AWID{1'b1}} << W;
  localparam logic [AWID-1:0] LANE_MASK =
    (REM != 0) ? (({AWID{1'b1}} << (M * REM)) & ~PAD_MASK) : '0;

  logic w_viol;
  logic r_err;

  assign w_viol = (|(r_asm & PAD_MASK)) | (w_last_row & (|(r_asm & LANE_MASK)));

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_err <= 1'b0;
    end else if (w_write && w_viol) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_ct_loader.sv
// Scoreboard bench for ct_loader: expected rows queued as chunks are accepted, popped on each ct_rw pulse.
module tb_ct_loader;
  localparam int M = 79, N = 47, DIGIT = 4;
  localparam int W = M * DIGIT;
  localparam int ROWS = (N + DIGIT - 1) / DIGIT;
  localparam int CPR = (W + 31) / 32;
  localparam int TOTAL = ROWS * CPR;
  localparam int AW = $clog2(ROWS);
  localparam int LAST_BITS = (N % DIGIT == 0) ? W : M * (N % DIGIT);

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic start = 1'b0;
  logic din_valid = 1'b0;
  logic [31:0] din = '0;
  wire din_ready, ct_rw, busy, done;
  wire [AW-1:0] ct_addr;
  wire [W-1:0] ct_dout;
`ifdef CT_LOAD_CHK_EN
  wire err;
`endif

  ct_loader #(.M(M), .N(N), .DIGIT(DIGIT)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .start(start),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .ct_addr(ct_addr),
    .ct_dout(ct_dout),
    .ct_rw(ct_rw),
    .busy(busy),
    .done(done)
`ifdef CT_LOAD_CHK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  wr_t exp_q[$];
  logic [CPR*32-1:0] mdl_asm;
  bit exp_err;
  logic [W-1:0] img [ROWS];
  logic [W-1:0] golden [ROWS];
  int done_cnt = 0;
  int done_cyc = 0;
  bit mon_en = 1'b0;

  // Chunk index as data, with bits outside the ciphertext's real lanes kept at zero.
  function automatic logic [31:0] chunk_val(input int idx);
    logic [31:0] v;
    int base;
    v = idx;
    base = (idx % CPR) * 32;
    for (int j = 0; j < 32; j++) begin
      if ((base + j >= W) || ((idx / CPR == ROWS - 1) && (base + j >= LAST_BITS))) v[j] = 1'b0;
    end
    return v;
  endfunction

  function automatic void accept(input logic [31:0] d, input int idx);
    mdl_asm[(idx % CPR) * 32 +: 32] = d;
    if (idx % CPR == CPR - 1) begin
      wr_t e;
      e.addr = AW'(idx / CPR);
      e.data = mdl_asm[W-1:0];
      exp_q.push_back(e);
      for (int j = W; j < CPR * 32; j++) if (mdl_asm[j]) exp_err = 1'b1;
      if (idx / CPR == ROWS - 1)
        for (int j = LAST_BITS; j < W; j++) if (mdl_asm[j]) exp_err = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (ct_rw) begin
        wr_t e;
        check("rdy_in_write", din_ready, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", ct_addr, e.addr);
          check("wr_data", ct_dout, e.data);
        end
        img[ct_addr] = ct_dout;
      end else begin
        check("or_merge_zero", {ct_addr, ct_dout}, '0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_in_done", busy, 1'b1);
`ifdef CT_LOAD_CHK_EN
        check("err_at_done", err, exp_err);
`endif
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check(tag, {din_ready, busy, done, ct_rw, ct_addr, ct_dout}, '0);
`ifdef CT_LOAD_CHK_EN
    check({tag, "_err"}, err, 1'b0);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_load(input bit gaps, input int restart_at, input int rst_at, input bit pad);
    int idx, gap, budget, start_cyc;
    bit pulsed;
    idx = 0; gap = 0; budget = 0; pulsed = 1'b0;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    exp_q.delete();
    exp_err = 1'b0;
    done_cnt = 0;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (idx < TOTAL && budget < 20000) begin
      budget++;
      if (idx == rst_at) begin
        rst_b = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid_load");
        rst_b = 1'b0;
        exp_q.delete();
        @(negedge clk);
        return;
      end
      start = 1'b0;
      if (idx == restart_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (gap > 0) begin
        din_valid = 1'b0;
        gap--;
      end else begin
        din_valid = 1'b1;
        din = chunk_val(idx);
        if (pad && idx == CPR - 1) din[31] = 1'b1;
        if (din_ready) begin
          accept(din, idx);
          idx++;
          if (gaps && $urandom_range(0, 2) == 0) gap = $urandom_range(1, 5);
        end
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    start = 1'b0;
    if (idx < TOTAL) check("feed_timeout", 1'b1, 1'b0);
    budget = 0;
    while (done_cnt == 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    if (!gaps) check("done_latency", done_cyc - start_cyc + 1, TOTAL + ROWS + 2);
    check("sb_empty", exp_q.size(), 0);
    check_idle_outputs("idle_after_load");
`ifdef CT_LOAD_CHK_EN
    check("err_sticky", err, exp_err);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
    mon_en = 1'b1;

    run_load(1'b0, -1, -1, 1'b0);
    check("row0_lo", ct_dout, '0);
    check("row0_chunk0", img[0][31:0], 32'd0);
    check("row0_chunk1", img[0][63:32], 32'd1);
    for (int r = 0; r < ROWS; r++) golden[r] = img[r];

    run_load(1'b1, -1, -1, 1'b0);
    for (int r = 0; r < ROWS; r++) check("img_gaps", img[r], golden[r]);

    run_load(1'b0, 37, -1, 1'b0);
    for (int r = 0; r < ROWS; r++) check("img_start_busy", img[r], golden[r]);

    run_load(1'b0, -1, 5 * CPR + 3, 1'b0);
    run_load(1'b0, -1, -1, 1'b0);
    for (int r = 0; r < ROWS; r++) check("img_after_rst", img[r], golden[r]);

    run_load(1'b0, -1, -1, 1'b1);
    for (int r = 0; r < ROWS; r++) check("img_pad", img[r], golden[r]);
`ifdef CT_LOAD_CHK_EN
    check("pad_err_model", exp_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ct_loader.md
Name: ct_loader

Overview:
- Receiver-side counterpart of the encrypt core's 32-bit ciphertext output.
- Accepts ciphertext as a stream of 32-bit words over a valid/ready handshake.
- Packs each group of words LSB-first into digit*m-bit rows and writes the rows into a single-port ct memory (mem_sp style) that feeds the decrypt datapath.
- Write-side outputs are forced to zero when the block is idle, so they can be OR-merged with other memory masters.

Parameters:
- M, 79: GF(2^m) element width.
- N, 47: ciphertext length in GF(2^m) elements.
- DIGIT, 4: elements per memory row.
- Derived, not overridable:
  - W = M*DIGIT (316), row width.
  - ROWS = ceil(N/DIGIT) (12), memory depth.
  - CPR = ceil(W/32) (10), chunks per row.
  - TOTAL = ROWS*CPR (120), chunks per ciphertext.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  reset, synchronous, active-high (1 = reset).
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE.
- din  in  32  ciphertext chunk.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- ct_addr  out  CLOG2(ROWS)  memory row address.
- ct_dout  out  W  memory write data.
- ct_rw  out  1  memory write enable.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last row has been written.
- err  out  1  padding violation flag; exists only with CT_LOAD_CHK_EN.

Behaviour:
- Reset values: all outputs 0; state IDLE; chunk counter, row counter and shift register cleared. Reset mid-load aborts immediately. Memory contents are not cleared.
- IDLE:
  - din_ready=0, busy=0, ct_rw=0, ct_addr=0, ct_dout=0.
  - start=1 → RECV, with row=0 and chunk=0.
- RECV:
  - din_ready=1, busy=1.
  - A transfer occurs on a cycle where din_valid & din_ready. The chunk lands at bits [32*chunk +: 32] of the CPR*32-bit assembly register, and chunk increments.
  - On the transfer where chunk==CPR-1 → WRITE, and chunk resets to 0.
  - No transfer → stay in RECV; no timeout.
- WRITE (exactly one cycle):
  - din_ready=0.
  - ct_rw=1, ct_addr=row, ct_dout=assembly[W-1:0]. Bits above W are discarded.
  - If row==ROWS-1 → DONE; otherwise row increments → RECV.
- DONE (one cycle): done=1, busy=1, ct_rw=0 → IDLE.
- Outside WRITE, ct_addr and ct_dout are 0 (OR-merge safe).
- Throughput: CPR+1 cycles per row when din_valid is held high. Latency from start to done is TOTAL+ROWS+2 cycles minimum (134 with defaults).
- start asserted in any state other than IDLE: ignored, with no effect on counters.
- din_valid while not in RECV: no transfer; din must be held by the source.
- The assembly register is not cleared between rows; every bit is overwritten before use.

Optional Feature:
- Macro: CT_LOAD_CHK_EN.
- Defined:
  - err port present, cleared by reset and on start.
  - err is set (sticky until next start or reset) when the row written in WRITE has nonzero bits in either location:
    - (a) assembly[CPR*32-1:W], the padding in the last chunk of any row;
    - (b) for the final row only, when N%DIGIT!=0, ct_dout[W-1:M*(N%DIGIT)], the unused lanes.
  - The data is still written unchanged; err does not stall the FSM.
- Not defined: err port absent; no checking logic.

Test Plan:
- Basic load:
  - Stimulus: reset, start, 120 chunks with din=chunk index and din_valid held high.
  - Response: 12 ct_rw pulses at addr 0..11; row0 ct_dout[31:0]=0 and [63:32]=1; done exactly 134 cycles after start; err=0.
- Backpressure and gaps:
  - Stimulus: random din_valid low gaps, 1–5 cycles.
  - Response: memory image identical to the basic load; din_ready=0 during every WRITE cycle.
- start while busy:
  - Stimulus: pulse start at chunk 37.
  - Response: no restart; counts continue; single done.
- Reset mid-load:
  - Stimulus: rst_b=1 at row 5.
  - Response: next cycle all outputs are 0. A new start then loads from row 0 correctly.
- OR-merge idle outputs:
  - Stimulus: sample the outputs in IDLE, RECV and DONE.
  - Response: ct_rw, ct_addr and ct_dout are all 0.
- Padding check (CT_LOAD_CHK_EN):
  - Stimulus: set bit 31 of chunk 9 of row 0 (absolute bit 319 ≥ W=316).
  - Response: err=1 after the row-0 write and stays 1 through done; without the macro the same stimulus gives an identical memory image and there is no err port.
